// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG trigger-wheel generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } vr_gen_state_t;

  localparam int VR_GEN_MIN_PERIOD  = 4;
  localparam int VR_GEN_DEF_TEETH   = 60;
  localparam int VR_GEN_DEF_MISSING = 2;

  // A wheel needs at least one physical tooth and at least one missing slot.
  function automatic logic vr_cfg_ok(input int unsigned t, input int unsigned m);
    return (t >= 2) && (m >= 1) && (m < t);
  endfunction

endpackage

// File: rtl/vr_tooth_timer.sv
// Loadable down-counter timing one HIGH/LOW/GAP phase; zero marks the phase's last cycle.
// Latency: load takes effect on the next clock; zero is combinational from the count.
// Backpressure: none; holds at zero until reloaded.
// Ports: clk, rst (async active-low), load/load_val (reload), en (count), zero (count==0).
module vr_tooth_timer #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [PW-1:0] load_val,
  output logic          zero
);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/vr_wheel_gen.sv
// Crank trigger-wheel emulator: T-M physical teeth, then M missing slots, repeating per revolution.
// Latency: ena high in cycle n from IDLE (valid config) gives raw vr_out high plus strobes in cycle n+1.
// Backpressure: none; free-running source, ena=0 aborts to IDLE on the next cycle without strobes.
// Ports: clk, rst (async active-low); ena, inv, period, teeth_total, teeth_missing in;
//        vr_out, tooth_idx, tooth_strb, rev_strb, active, cfg_err out.
module vr_wheel_gen
  import hwag_pkg::*;
#(
  parameter int PW = 16,
  parameter int TW = 6,
  parameter int MW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          inv,
  input  logic [PW-1:0] period,
  input  logic [TW-1:0] teeth_total,
  input  logic [MW-1:0] teeth_missing,
  output logic          vr_out,
  output logic [TW-1:0] tooth_idx,
  output logic          tooth_strb,
  output logic          rev_strb,
  output logic          active,
  output logic          cfg_err
);

  localparam logic [PW-1:0] MIN_P = PW'(VR_GEN_MIN_PERIOD);

  vr_gen_state_t state_q, state_d;
  logic [TW-1:0] idx_q, idx_d;
  logic [TW-1:0] t_q, t_d;
  logic [MW-1:0] m_q, m_d;
  logic [PW-1:0] p_q, p_d;
  logic          tooth_strb_q, tooth_strb_d;
  logic          rev_strb_q, rev_strb_d;
  logic          cfg_err_q, cfg_err_d;

  logic [PW-1:0] p_in, h_in, l_cur, tmr_val;
  logic          tmr_load, tmr_zero, tmr_en, new_ok;
  logic [TW:0]   idx_inc, phys_cnt;

  // Period is clamped and sampled at every slot start; the LOW phase reuses the
  // slot's latched period so a mid-slot change cannot stretch the current slot.
  assign p_in     = (period < MIN_P) ? MIN_P : period;
  assign h_in     = p_in >> 1;
  assign l_cur    = p_q - (p_q >> 1);
  assign idx_inc  = {1'b0, idx_q} + (TW+1)'(1);
  assign phys_cnt = {1'b0, t_q} - (TW+1)'(m_q);
  assign new_ok   = vr_cfg_ok(32'(teeth_total), 32'(teeth_missing));
  assign tmr_en   = (state_q != IDLE);

  vr_tooth_timer #(.PW(PW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    t_d          = t_q;
    m_d          = m_q;
    p_d          = p_q;
    tooth_strb_d = 1'b0;
    rev_strb_d   = 1'b0;
    cfg_err_d    = cfg_err_q;
    tmr_load     = 1'b0;
    tmr_val      = h_in - PW'(1);

    if (!ena) begin
      // Abort wins over everything, including a wrap in the same cycle.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          t_d   = teeth_total;
          m_d   = teeth_missing;
          idx_d = '0;
          if (new_ok) begin
            state_d      = HIGH;
            p_d          = p_in;
            tmr_load     = 1'b1;
            tooth_strb_d = 1'b1;
            rev_strb_d   = 1'b1;
            cfg_err_d    = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        HIGH: begin
          if (tmr_zero) begin
            state_d  = LOW;
            tmr_load = 1'b1;
            tmr_val  = l_cur - PW'(1);
          end
        end
        LOW: begin
          if (tmr_zero) begin
            idx_d    = idx_inc[TW-1:0];
            p_d      = p_in;
            tmr_load = 1'b1;
            if (idx_inc < phys_cnt) begin
              state_d      = HIGH;
              tooth_strb_d = 1'b1;
            end else begin
              state_d = GAP;
              tmr_val = p_in - PW'(1);
            end
          end
        end
        GAP: begin
          if (tmr_zero) begin
            if (idx_q == t_q - TW'(1)) begin
              // Revolution wrap: the only point where T/M are re-shadowed.
              t_d   = teeth_total;
              m_d   = teeth_missing;
              idx_d = '0;
              if (new_ok) begin
                state_d      = HIGH;
                p_d          = p_in;
                tmr_load     = 1'b1;
                tooth_strb_d = 1'b1;
                rev_strb_d   = 1'b1;
              end else begin
                state_d   = IDLE;
                cfg_err_d = 1'b1;
              end
            end else begin
              idx_d    = idx_inc[TW-1:0];
              p_d      = p_in;
              tmr_load = 1'b1;
              tmr_val  = p_in - PW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      t_q          <= TW'(VR_GEN_DEF_TEETH);
      m_q          <= MW'(VR_GEN_DEF_MISSING);
      p_q          <= MIN_P;
      tooth_strb_q <= 1'b0;
      rev_strb_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      t_q          <= t_d;
      m_q          <= m_d;
      p_q          <= p_d;
      tooth_strb_q <= tooth_strb_d;
      rev_strb_q   <= rev_strb_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Polarity applies outside reset only; in reset the pin sits at raw low.
  assign vr_out     = rst & ((state_q == HIGH) ^ inv);
  assign tooth_idx  = idx_q;
  assign tooth_strb = tooth_strb_q;
  assign rev_strb   = rev_strb_q;
  assign active     = (state_q != IDLE);
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_vr_wheel_gen.sv
// Self-checking bench for vr_wheel_gen: slot-position reference model plus directed wheel scenarios.
// Latency: model predicts each cycle's outputs from slot index / offset within slot.
// Backpressure: n/a.
module tb_vr_wheel_gen;

  localparam int PW = 16;
  localparam int TW = 6;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          inv;
  logic [PW-1:0] period;
  logic [TW-1:0] teeth_total;
  logic [MW-1:0] teeth_missing;
  logic          vr_out;
  logic [TW-1:0] tooth_idx;
  logic          tooth_strb;
  logic          rev_strb;
  logic          active;
  logic          cfg_err;

  vr_wheel_gen #(.PW(PW), .TW(TW), .MW(MW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .inv           (inv),
    .period        (period),
    .teeth_total   (teeth_total),
    .teeth_missing (teeth_missing),
    .vr_out        (vr_out),
    .tooth_idx     (tooth_idx),
    .tooth_strb    (tooth_strb),
    .rev_strb      (rev_strb),
    .active        (active),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: wheel position as (slot k, offset c within slot of length ps).
  bit m_run, m_err;
  int m_k, m_c, m_ps, m_tt, m_mm;
  bit o_tooth, o_rev, o_raw, o_vr;

  function automatic bit cfg_ok(input int t, input int m);
    return (t >= 2) && (m >= 1) && (m < t);
  endfunction

  function automatic int clamp_p(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_err = 1'b0;
    m_k   = 0;
    m_c   = 0;
  endtask

  // Compare this cycle's outputs at the falling edge, then advance the model
  // using this cycle's inputs; returns 1 time unit after the next rising edge.
  task automatic cycle();
    int phys;
    bit e_raw;
    @(negedge clk);
    phys  = m_tt - m_mm;
    e_raw = m_run && (m_k < phys) && (m_c < m_ps / 2);
    check_eq("vr_out",     32'(vr_out),     32'(e_raw ^ inv));
    check_eq("tooth_idx",  32'(tooth_idx),  m_run ? 32'(m_k) : 32'd0);
    check_eq("tooth_strb", 32'(tooth_strb), 32'(m_run && (m_k < phys) && (m_c == 0)));
    check_eq("rev_strb",   32'(rev_strb),   32'(m_run && (m_k == 0) && (m_c == 0)));
    check_eq("active",     32'(active),     32'(m_run));
    check_eq("cfg_err",    32'(cfg_err),    32'(m_err));
    o_tooth = tooth_strb;
    o_rev   = rev_strb;
    o_vr    = vr_out;
    o_raw   = vr_out ^ inv;
    if (!ena) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (cfg_ok(int'(teeth_total), int'(teeth_missing))) begin
        m_run = 1'b1; m_k = 0; m_c = 0;
        m_ps  = clamp_p(int'(period));
        m_tt  = int'(teeth_total);
        m_mm  = int'(teeth_missing);
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_c++;
      if (m_c == m_ps) begin
        m_c = 0;
        m_k++;
        if (m_k == m_tt) begin
          if (cfg_ok(int'(teeth_total), int'(teeth_missing))) begin
            m_k  = 0;
            m_ps = clamp_p(int'(period));
            m_tt = int'(teeth_total);
            m_mm = int'(teeth_missing);
          end else begin
            m_run = 1'b0;
            m_err = 1'b1;
          end
        end else begin
          m_ps = clamp_p(int'(period));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rev(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      cycle();
      got = o_rev;
    end
    check_eq({tag, "_sync"}, 32'(got), 32'd1);
  endtask

  // One revolution from a rev_strb: length, physical tooth count, longest raw-low run.
  task automatic measure_rev(input string tag, input int exp_len, input int exp_teeth, input int exp_gap);
    int n_t, run_len, max_run;
    wait_rev(tag);
    n_t = int'(o_tooth);
    run_len = 0;
    max_run = 0;
    for (int i = 1; i < exp_len; i++) begin
      cycle();
      n_t += int'(o_tooth);
      if (!o_raw) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
    cycle();
    check_eq({tag, "_rev_len"}, 32'(o_rev), 32'd1);
    check_eq({tag, "_teeth"}, 32'(n_t), 32'(exp_teeth));
    check_eq({tag, "_gap_low"}, 32'(max_run), 32'(exp_gap));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_vr_out"}, 32'(vr_out), 32'd0);
    check_eq({tag, "_idx"}, 32'(tooth_idx), 32'd0);
    check_eq({tag, "_tooth_strb"}, 32'(tooth_strb), 32'd0);
    check_eq({tag, "_rev_strb"}, 32'(rev_strb), 32'd0);
    check_eq({tag, "_active"}, 32'(active), 32'd0);
    check_eq({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int n;
    bit reached, prev_vr;
    rst = 1'b0; ena = 1'b0; inv = 1'b1;
    period = 16'd8; teeth_total = 6'd60; teeth_missing = 2'd2;
    model_reset();
    m_ps = 4; m_tt = 60; m_mm = 2;
    #1;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b1; inv = 1'b0;

    // 60-2 at period 8.
    ena = 1'b1;
    measure_rev("w60_2", 480, 58, 20);

    // 36-1 at period 3 (clamped to 4); takes effect from the next revolution.
    teeth_total = 6'd36; teeth_missing = 2'd1; period = 16'd3;
    measure_rev("w36_1", 144, 35, 6);

    // Odd period with inverted output: each strobe lands on a vr_out falling edge.
    period = 16'd9; inv = 1'b1;
    measure_rev("p9_inv", 324, 35, 14);
    prev_vr = o_vr;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (o_tooth) check_eq("strb_on_fall", 32'({prev_vr, o_vr}), 32'd2);
      prev_vr = o_vr;
    end

    // Period ramp 8 -> 16 inside slot 10; T/M change only after the wrap.
    inv = 1'b0; teeth_total = 6'd60; teeth_missing = 2'd2; period = 16'd8;
    wait_rev("ramp_pre");
    reached = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      reached = m_run && (m_k == 10) && (m_c == 3);
      if (!reached) cycle();
    end
    check_eq("ramp_reach", 32'(reached), 32'd1);
    period = 16'd16; teeth_total = 6'd36; teeth_missing = 2'd1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!o_rev && n < 2000);
    check_eq("ramp_to_wrap", 32'(n), 32'd790);
    measure_rev("ramp_after", 576, 35, 24);

    // Invalid config then fix.
    ena = 1'b0;
    cycle();
    teeth_total = 6'd2; teeth_missing = 2'd2; ena = 1'b1; inv = 1'b1;
    repeat (4) cycle();
    check_eq("bad_cfg_err", 32'(cfg_err), 32'd1);
    check_eq("bad_cfg_active", 32'(active), 32'd0);
    check_eq("bad_cfg_vr", 32'(vr_out), 32'd1);
    teeth_missing = 2'd1;
    cycle();
    check_eq("fix_active", 32'(active), 32'd1);
    check_eq("fix_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("fix_rev", 32'(rev_strb), 32'd1);

    // Abort mid-HIGH at idx 30.
    inv = 1'b0; teeth_total = 6'd60; teeth_missing = 2'd2; period = 16'd8;
    reached = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      reached = m_run && (m_tt == 60) && (m_k == 30) && (m_c == 1);
      if (!reached) cycle();
    end
    check_eq("abort_reach", 32'(reached), 32'd1);
    ena = 1'b0;
    cycle();
    check_eq("abort_idx", 32'(tooth_idx), 32'd0);
    check_eq("abort_active", 32'(active), 32'd0);
    ena = 1'b1;
    repeat (40) cycle();

    // Asynchronous reset during GAP.
    reached = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      reached = m_run && (m_k >= m_tt - m_mm);
      if (!reached) cycle();
    end
    check_eq("gap_reach", 32'(reached), 32'd1);
    inv = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    cycle();
    check_eq("arst_restart_rev", 32'(o_rev), 32'd1);
    check_eq("arst_restart_idx", 32'(tooth_idx), 32'd0);

    // Randomized episodes: config, period ramps, polarity and enable drops.
    for (int ep = 0; ep < 16; ep++) begin
      int len;
      teeth_total   = TW'($urandom_range(63, 2));
      teeth_missing = MW'($urandom_range(3, 1));
      if ($urandom_range(7) == 0) begin
        teeth_total   = TW'($urandom_range(63, 0));
        teeth_missing = MW'($urandom_range(3, 0));
      end
      period = PW'($urandom_range(20, 0));
      inv    = 1'($urandom_range(1, 0));
      ena    = 1'b1;
      len    = int'($urandom_range(1500, 300));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(15) == 0) period = PW'($urandom_range(20, 0));
        if ($urandom_range(99) == 0) inv = ~inv;
        if ($urandom_range(199) == 0) begin
          teeth_total   = TW'($urandom_range(63, 0));
          teeth_missing = MW'($urandom_range(3, 0));
        end
        if ($urandom_range(299) == 0) ena = 1'b0;
        else if (!ena && $urandom_range(7) == 0) ena = 1'b1;
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vr_wheel_gen.md
Name: vr_wheel_gen

Overview:
Crank trigger-wheel emulator that generates the VR tooth pattern the HWAG capture path consumes, for example 60-2 or 36-1. It drives a digital tooth waveform with a configurable tooth period, tooth count and missing-tooth gap. Outputs feed the HWAG vr_in (bench or FPGA loopback) for closed-loop testing without an engine. It also emits tooth and revolution strobes as ground truth for checking capture and angle logic.

Parameters:
PW, 16, tooth period counter width in clocks
TW, 6, tooth count / index width
MW, 2, missing-tooth count width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
ena  input  1  run enable; level-sensitive
inv  input  1  output polarity invert (matches capture edge select)
period  input  PW  tooth period in clocks
teeth_total  input  TW  teeth per revolution including missing (T)
teeth_missing  input  MW  missing teeth at end of revolution (M)
vr_out  output  1  generated tooth waveform
tooth_idx  output  TW  current tooth position 0..T-1
tooth_strb  output  1  one-clock pulse at each physical tooth rising edge
rev_strb  output  1  one-clock pulse at the start of tooth 0
active  output  1  generator running
cfg_err  output  1  configuration rejected at last start attempt

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous, active-low.
- Reset values: vr_out=0 (raw level, inv not applied in reset), tooth_idx=0, strobes=0, active=0, cfg_err=0, state=IDLE.
- vr_out = raw_level XOR inv whenever not in reset. raw_level is low in IDLE.
- Period clamp: p = max(period, 4).
  - High phase H = p>>1 clocks.
  - Low phase L = p - H clocks.
  - Each tooth slot lasts exactly p clocks.
- Shadowing:
  - T and M are sampled on start and at every revolution wrap only.
  - period is sampled at the start of every tooth slot, so period ramps emulate acceleration.
- Config valid iff T >= 2, M >= 1 and M < T. M=0 is not supported.
- States: IDLE, HIGH, LOW, GAP.
  - IDLE: when ena=1 and config valid, go to HIGH next cycle. Set tooth_idx=0, pulse rev_strb and tooth_strb, active=1, cfg_err=0.
  - IDLE with invalid config: stay in IDLE and set cfg_err=1 (held until the next valid start).
  - HIGH: raw_level=1 for H cycles, then LOW.
  - LOW: raw_level=0 for L cycles. Then:
    - if tooth_idx+1 < T-M: tooth_idx++, go to HIGH, pulse tooth_strb.
    - else: tooth_idx++, go to GAP.
  - GAP: raw_level=0 for p cycles per missing slot; tooth_idx increments at each slot boundary. After slot T-1 completes, wrap:
    - resample T/M; tooth_idx=0;
    - if the new config is valid: go to HIGH and pulse rev_strb and tooth_strb together;
    - if invalid: go to IDLE, set cfg_err=1, active=0.
- Latency: ena high in cycle n from IDLE gives vr_out high (raw) in cycle n+1.
- ena=0 in any state aborts immediately. The next cycle is IDLE with raw_level=0, active=0 and tooth_idx=0. No strobes are issued on abort.
- ena re-asserted in the same cycle the wrap occurs: the wrap takes precedence only if ena=1; ena=0 always wins.
- Phase counter: a down-counter loaded with length-1, advancing on 0. Period changes mid-slot do not affect the current slot.
- Revolution length = T*p clocks when period is constant. Gap low time = L + M*p clocks.

Decomposition:
- Shared package hwag_pkg:
  - state enum vr_gen_state_t {IDLE, HIGH, LOW, GAP};
  - constants VR_GEN_MIN_PERIOD=4, VR_GEN_DEF_TEETH=60, VR_GEN_DEF_MISSING=2.
- One sub-module, vr_tooth_timer: a PW-bit loadable down-counter with load, enable and zero flag. It is used for the phase timing.

Test Plan:
- 60-2, period=8, inv=0, ena held: 58 tooth_strb per 480-clock revolution, vr_out high 4 / low 4. Gap low run = 20 clocks, rev_strb every 480 clocks, tooth_idx sequence 0..59.
- 36-1, period=3 (clamped to 4): H=2, L=2, revolution = 144 clocks, gap low = 6 clocks.
- Period odd (9) with inv=1: raw high 4 / low 5, so vr_out low 4 / high 5. The tooth_strb cycle coincides with the vr_out falling edge.
- Period changed 8→16 mid-tooth at idx 10: slot 10 stays 8 clocks, slot 11 onward is 16. teeth_total changed mid-revolution only takes effect after the wrap.
- Invalid config (T=2, M=2), ena=1: cfg_err=1, active=0, vr_out=inv, no strobes. Fix to M=1: start on the next cycle, cfg_err clears.
- Abort/reset: drop ena mid-HIGH at idx 30, so the next cycle is IDLE with idx=0. Assert rst during GAP: all outputs go to reset values asynchronously, and after release the generator restarts at idx 0 with rev_strb.
